// File: rtl/mod10_counter.sv
// Free-running modulo-MODULUS counter with asynchronous active-low reset.
// tc flags the last count and is meant to enable the next cascaded stage.
module mod10_counter #(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > 16 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_param
    $error("mod10_counter: MODULUS must be 2..16 and fit in WIDTH bits");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // The >= compare folds the wrap and illegal-state recovery into one path.
  always_comb begin
    q_d = q_q + WIDTH'(1);
    if (q_q >= LAST) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign tc = (q_q == LAST);

endmodule

// File: tb/tb_mod10_counter.sv
// Directed bench for mod10_counter: reset, sequence, terminal count,
// mid-count reset, illegal-state recovery and a MODULUS=6 instance.
module tb_mod10_counter;

  logic       clk;
  logic       rst;
  logic [3:0] Q;
  logic       tc;
  logic [2:0] Q6;
  logic       tc6;

  int n_cmp = 0;
  int n_err = 0;

  mod10_counter #(.MODULUS(10), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .Q(Q), .tc(tc)
  );

  mod10_counter #(.MODULUS(6), .WIDTH(3)) dut6 (
    .clk(clk), .rst(rst), .Q(Q6), .tc(tc6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges 2..25 after reset release.
  int exp_seq [24] = '{2,3,4,5,6,7,8,9,0,1,2,3,4,5,6,7,8,9,0,1,2,3,4,5};
  int exp_seq6[24] = '{2,3,4,5,0,1,2,3,4,5,0,1,2,3,4,5,0,1,2,3,4,5,0,1};
  int exp_tc  [24] = '{0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0};
  int exp_tc6 [24] = '{0,0,0,1,0,0,0,0,0,1,0,0,0,0,0,1,0,0,0,0,0,1,0,0};
  int exp_rst [10] = '{1,2,3,4,5,6,7,8,9,0};
  int exp_ill [4]  = '{0,1,2,3};

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_cmp++; if (Q !== 4'd0) begin n_err++; $display("FAIL reset_q_initial: got %0d want 0", Q); end
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc_initial: got %b want 0", tc); end
    #5; // past the posedge at 5 ns, reset still low
    n_cmp++; if (Q !== 4'd0) begin n_err++; $display("FAIL reset_q_hold: got %0d want 0", Q); end
    n_cmp++; if (Q6 !== 3'd0) begin n_err++; $display("FAIL reset_q6_hold: got %0d want 0", Q6); end
    #3;
    rst = 1'b1; // 10 ns, on a falling edge
    @(posedge clk); #1;
    n_cmp++; if (Q !== 4'd1) begin n_err++; $display("FAIL release_first_edge: got %0d want 1", Q); end
    n_cmp++; if (Q6 !== 3'd1) begin n_err++; $display("FAIL release_first_edge6: got %0d want 1", Q6); end
  endtask

  task automatic test_sequence_tc();
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (Q !== 4'(exp_seq[i])) begin
        n_err++; $display("FAIL seq[%0d]: got %0d want %0d", i, Q, exp_seq[i]);
      end
      n_cmp++;
      if (tc !== 1'(exp_tc[i])) begin
        n_err++; $display("FAIL tc[%0d]: got %b want %0d (Q=%0d)", i, tc, exp_tc[i], Q);
      end
      n_cmp++;
      if (Q6 !== 3'(exp_seq6[i])) begin
        n_err++; $display("FAIL seq6[%0d]: got %0d want %0d", i, Q6, exp_seq6[i]);
      end
      n_cmp++;
      if (tc6 !== 1'(exp_tc6[i])) begin
        n_err++; $display("FAIL tc6[%0d]: got %b want %0d (Q6=%0d)", i, tc6, exp_tc6[i], Q6);
      end
    end
  endtask

  task automatic test_midcount_reset();
    n_cmp++; if (Q !== 4'd5) begin n_err++; $display("FAIL mid_pre: got %0d want 5", Q); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (Q !== 4'd0) begin n_err++; $display("FAIL mid_async: got %0d want 0", Q); end
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL mid_async_tc: got %b want 0", tc); end
    @(posedge clk); #1;
    n_cmp++; if (Q !== 4'd0) begin n_err++; $display("FAIL mid_hold: got %0d want 0", Q); end
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (Q !== 4'(exp_rst[i])) begin
        n_err++; $display("FAIL mid_restart[%0d]: got %0d want %0d", i, Q, exp_rst[i]);
      end
    end
  endtask

  task automatic test_illegal_state();
    @(negedge clk);
    force dut.q_q = 4'd12;
    #1;
    release dut.q_q;
    #1;
    n_cmp++; if (Q !== 4'd12) begin n_err++; $display("FAIL illegal_loaded: got %0d want 12", Q); end
    n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL illegal_tc: got %b want 0", tc); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (Q !== 4'(exp_ill[i])) begin
        n_err++; $display("FAIL illegal_recover[%0d]: got %0d want %0d", i, Q, exp_ill[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_sequence_tc();
    test_midcount_reset();
    test_illegal_state();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod10_counter.md
# mod10_counter

Free-running synchronous decade (modulo-10) counter with asynchronous active-low reset. It counts 0 through 9 on rising clock edges and wraps to 0, giving a 4-bit binary count and a one-cycle terminal-count flag. It serves as a decade stage for timers, BCD display digits and clock dividers, where `tc` feeds the enable of the next stage.

## Interface
- `MODULUS`, default 10: count length; the count sequence is 0 .. MODULUS-1. Legal range is 2..16. Default use is 10.
- `WIDTH`, default 4: width of `Q`. Must satisfy 2^WIDTH >= MODULUS.
- `clk`  input  1  single clock; all state changes occur on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low (asserted at 0).
- `Q`  output  WIDTH  current count, unsigned binary, registered.
- `tc`  output  1  terminal count; high while `Q` == MODULUS-1. Decoded combinationally from the `Q` register. May be left unconnected.

## Operation
- Reset: while `rst` == 0, `Q` = 0 and `tc` = 0 (with default MODULUS). Reset takes effect immediately, independent of `clk`, and holds for as long as `rst` stays low.
- Counting: on each rising `clk` edge while `rst` == 1:
  - if `Q` == MODULUS-1, then `Q` <= 0;
  - otherwise `Q` <= `Q` + 1.
- There is no enable input; the counter advances on every edge while out of reset.
- Sequence with default parameters: 0,1,2,3,4,5,6,7,8,9,0,1,…, a period of 10 clock cycles.
- Illegal states (`Q` >= MODULUS, i.e. 10..15 for the default): the next rising edge loads 0. The counter can never lock up.
- Arithmetic: the increment is WIDTH bits wide with no carry out. Wrap is controlled only by the compare against MODULUS-1.
- `tc` = 1 exactly when `Q` == MODULUS-1 (9 by default), and 0 in every other state, including illegal states.

## Timing
- Latency: `Q` updates one clk-to-q delay after each rising edge. `tc` follows `Q` combinationally within the same cycle.
- Reset assertion: asynchronous. `Q` goes to 0 without waiting for a clock edge, including mid-count.
- Reset release: the first rising edge with `rst` == 1 moves `Q` from 0 to 1.
- Reset and clock edge at the same time: reset wins and `Q` stays 0.
- `tc` is high for exactly one clock period out of every MODULUS periods in steady state.
- No reset synchronizer inside the block. The system must release `rst` synchronously to `clk` or meet recovery/removal timing.

## Test plan
- Power-up reset: with a 10 ns clock, hold `rst` = 0 for 10 ns, then release.
  - Required: `Q` = 0 during reset.
  - Required: `Q` = 1 after the first rising edge following release.
- Full sequence and wrap: run 25 rising edges after release.
  - Required: `Q` steps 1..9, 0, 1..9, 0, 1..5.
  - Required: every step is +1 except 9 -> 0.
- Terminal count: across 20 cycles of counting.
  - Required: `tc` = 1 only in the cycles where `Q` == 9 (two one-cycle pulses spaced 10 cycles apart).
  - Required: `tc` = 0 in all other cycles.
- Mid-count reset: after 25 edges (`Q` == 5), drive `rst` = 0 between clock edges for 10 ns.
  - Required: `Q` = 0 immediately, before the next edge, and stays 0 while `rst` is low.
  - Required: after release, the count restarts 1, 2, 3… for 10 more edges and wraps 9 -> 0.
- Illegal-state recovery: force the `Q` register to 12 and release the force.
  - Required: `Q` = 0 after the next rising edge, then normal counting 1, 2, ….
- Parameter check: instantiate with MODULUS = 6.
  - Required: the sequence is 0..5, 0.
  - Required: `tc` is high when `Q` == 5.
